regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of the regfile being driven.
REQ-002 SHALL have parameter NREGS, fixed at 8, number of registers sequenced (index width 3).
REQ-003 SHALL have one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-004 clk  input  1  rising-edge clock, shared with the regfile.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 load_valid  input  1  load-stream word present.
REQ-007 load_ready  output  1  sequencer accepts a load word this cycle.
REQ-008 load_data  input  WIDTH  load-stream word.
REQ-009 dump_req  input  1  request to read out R0..R7.
REQ-010 dump_valid  output  1  dump_data/dump_idx valid.
REQ-011 dump_ready  input  1  consumer accepts the dump word.
REQ-012 dump_data  output  WIDTH  registered value read from the regfile.
REQ-013 dump_idx  output  3  register number of dump_data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of a load or dump sequence.
REQ-016 rf_write, rf_writenum[2:0], rf_data_in[WIDTH-1:0]  output  regfile write port (write, writenum, data_in).
REQ-017 rf_readnum[2:0] output, rf_data_out[WIDTH-1:0] input  regfile read port; rf_data_out is combinational from rf_readnum.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DUMP_RD, DUMP_OUT, plus a 3-bit index counter idx.
REQ-019 load_ready SHALL be 1 in IDLE and LOAD, and 0 otherwise.
REQ-020 Load handshake: the cycle in which load_valid && load_ready holds is a beat.
- rf_write = 1, combinational, on that cycle.
- rf_writenum = idx, rf_data_in = load_data.
- idx increments at the following clk edge.
REQ-021 IDLE + beat -> LOAD. idx becomes 1.
REQ-022 LOAD + beat with idx==7 -> IDLE. idx wraps to 0; done pulses on the next cycle.
REQ-023 LOAD without a beat SHALL hold state and idx. Gaps in load_valid are allowed indefinitely.
REQ-024 rf_write SHALL be 0 in every cycle without a beat. rf_writenum and rf_data_in are don't-care then.
REQ-025 IDLE + dump_req + no load_valid -> DUMP_RD with idx=0.
REQ-026 IDLE with load_valid and dump_req both high: load SHALL win and dump_req is dropped.
REQ-027 DUMP_RD:
- rf_readnum = idx.
- At the next edge, dump_data <= rf_data_out and dump_idx <= idx.
- Then -> DUMP_OUT.
REQ-028 DUMP_OUT:
- dump_valid = 1.
- dump_data and dump_idx are held stable until dump_ready.
REQ-029 DUMP_OUT + dump_ready:
- If idx==7: -> IDLE, idx=0, done pulses next cycle.
- Else: idx+1 and -> DUMP_RD.
REQ-030 Latency:
- First dump_valid 2 cycles after dump_req is sampled in IDLE.
- Per word: 2 cycles minimum (DUMP_RD, DUMP_OUT).
- Full dump with dump_ready tied high: 16 cycles.
REQ-031 dump_req in LOAD/DUMP_RD/DUMP_OUT and load_valid in DUMP_* SHALL be ignored, with no effect on state.
REQ-032 rf_readnum SHALL equal idx in DUMP_RD, and hold its last value otherwise. It is never X after reset.
REQ-033 busy = (state != IDLE). done SHALL be registered and high for exactly one cycle per completed sequence.

Reset
REQ-034 reset_n low SHALL asynchronously force:
- state=IDLE, idx=0;
- dump_valid=0, dump_data=0, dump_idx=0;
- done=0, busy=0, rf_write=0, rf_readnum=0.
REQ-035 Reset mid-LOAD or mid-DUMP SHALL abort the sequence without a done pulse. Regfile contents already written are not restored.
REQ-036 After reset_n rises, the first clk edge SHALL be able to accept a load beat.

Verification
REQ-037 Load 10..17 with load_valid held high for 8 cycles -> rf_write high 8 cycles, writenum 0..7, busy 7 cycles, done 1 cycle; regfile R0..R7 = 10..17.
REQ-038 After REQ-037, dump_req with dump_ready=1 -> dump_valid on (idx, data) = (0,10)...(7,17), first valid 2 cycles after req, done after idx 7.
REQ-039 Dump with dump_ready low for 5 cycles at idx 3 -> dump_data=13, dump_idx=3 stable all 5 cycles; no readnum advance.
REQ-040 Load with load_valid gaps (1,0,0,1,...) -> only valid cycles write; writenum sequence contiguous 0..7; dump_req raised during LOAD ignored.
REQ-041 Simultaneous load_valid and dump_req in IDLE -> LOAD entered, R0 written, no dump_valid.
REQ-042 reset_n low at load beat 4 -> outputs zero at once; next load writes R0 first; no done pulse from the aborted sequence.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Streams eight words from a load handshake into an external register file
//   (R0..R7 in order), or reads R0..R7 back out through a dump handshake.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   load_valid/ready/data load stream; each valid&&ready cycle writes one register
//   dump_req              start a read-out of R0..R7 (only honoured in IDLE)
//   dump_valid/ready      dump handshake; dump_data/dump_idx held until ready
//   dump_data, dump_idx   registered register value and its number
//   busy                  high whenever a sequence is in progress
//   done                  one-cycle pulse after the last word of a sequence
//   rf_write, rf_writenum, rf_data_in   regfile write port
//   rf_readnum, rf_data_out             regfile read port (combinational read)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting; a load beat starts LOAD, else dump_req starts a dump
// S_LOAD     | writing R[idx] on each beat until R7 is written
// S_DUMP_RD  | rf_readnum = idx; capture rf_data_out into dump_data
// S_DUMP_OUT | presenting dump_data/dump_idx until dump_ready

module regfile_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dump_req,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [WIDTH-1:0] dump_data,
    output logic [2:0]       dump_idx,
    output logic             busy,
    output logic             done,
    output logic             rf_write,
    output logic [2:0]       rf_writenum,
    output logic [WIDTH-1:0] rf_data_in,
    output logic [2:0]       rf_readnum,
    input  logic [WIDTH-1:0] rf_data_out
);

    localparam logic [2:0] LAST_IDX = 3'(NREGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP_RD,
        S_DUMP_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [WIDTH-1:0] dump_data_q, dump_data_d;
    logic [2:0]       dump_idx_q, dump_idx_d;
    logic             done_q, done_d;
    logic [2:0]       readnum_q, readnum_d;
    logic             beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dump_data_q <= '0;
            dump_idx_q  <= '0;
            done_q      <= 1'b0;
            readnum_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
            dump_idx_q  <= dump_idx_d;
            done_q      <= done_d;
            readnum_q   <= readnum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        dump_idx_d  = dump_idx_q;
        readnum_d   = readnum_q;
        done_d      = 1'b0;

        load_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
        // Gated by reset_n so no write strobe escapes while reset is held.
        beat        = load_valid && load_ready && reset_n;

        rf_write    = beat;
        rf_writenum = idx_q;
        rf_data_in  = load_data;

        dump_valid  = (state_q == S_DUMP_OUT);
        // The read address only moves during DUMP_RD; otherwise it parks on
        // the last register read so the regfile read port stays quiet.
        rf_readnum  = (state_q == S_DUMP_RD) ? idx_q : readnum_q;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    state_d = S_LOAD;
                    idx_d   = 3'd1;
                end else if (dump_req) begin
                    state_d = S_DUMP_RD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_DUMP_RD: begin
                dump_data_d = rf_data_out;
                dump_idx_d  = idx_q;
                readnum_d   = idx_q;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dump_data = dump_data_q;
    assign dump_idx  = dump_idx_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_valid, load_ready;
    logic [15:0] load_data;
    logic        dump_req, dump_valid, dump_ready;
    logic [15:0] dump_data;
    logic [2:0]  dump_idx;
    logic        busy, done;
    logic        rf_write;
    logic [2:0]  rf_writenum, rf_readnum;
    logic [15:0] rf_data_in, rf_data_out;

    always #5 clk = ~clk;

    regfile_sequencer #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx),
        .busy(busy), .done(done),
        .rf_write(rf_write), .rf_writenum(rf_writenum), .rf_data_in(rf_data_in),
        .rf_readnum(rf_readnum), .rf_data_out(rf_data_out)
    );

    // Register file the sequencer drives.
    logic [15:0] rf_mem [8];
    always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    assign rf_data_out = rf_mem[rf_readnum];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: mode 0 idle, 1 loading, 2 dumping.
    // m_n = word number within the sequence, m_fetch = word m_n not yet presented.
    int          m_mode = 0, m_n = 0;
    bit          m_fetch = 0, m_done = 0;
    int          m_rdn = 0;
    logic [15:0] shadow [8];

    // Observation counters used by the directed literal checks.
    int          cyc = 0;
    int          wr_cnt, busy_cnt, done_cnt, valid_cnt, acc_cnt, stall_cnt;
    int          req_cyc, fv_cyc;
    logic [15:0] acc [8];

    task automatic clr_stats();
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; valid_cnt = 0;
        acc_cnt = 0; stall_cnt = 0; req_cyc = -1; fv_cyc = -1;
    endtask

    always @(negedge clk) begin
        bit beat;
        bit pres;
        cyc++;
        if (!reset_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_dump_valid", dump_valid, 0);
            chk("rst_dump_data", dump_data, 0);
            chk("rst_dump_idx", dump_idx, 0);
            chk("rst_rf_write", rf_write, 0);
            chk("rst_readnum", rf_readnum, 0);
            m_mode = 0; m_n = 0; m_fetch = 0; m_done = 0; m_rdn = 0;
        end else begin
            beat = load_valid && (m_mode != 2);
            pres = (m_mode == 2) && !m_fetch;
            chk("load_ready", load_ready, (m_mode != 2));
            chk("rf_write", rf_write, beat);
            if (beat) begin
                chk("rf_writenum", rf_writenum, m_n);
                chk("rf_data_in", rf_data_in, load_data);
            end
            chk("busy", busy, (m_mode != 0));
            chk("done", done, m_done);
            chk("dump_valid", dump_valid, pres);
            if (pres) begin
                chk("dump_idx", dump_idx, m_n);
                chk("dump_data", dump_data, shadow[m_n]);
            end
            chk("rf_readnum", rf_readnum, (m_mode == 2 && m_fetch) ? m_n : m_rdn);

            if (rf_write) wr_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (dump_valid) valid_cnt++;
            if (dump_valid && dump_ready) begin acc[dump_idx] = dump_data; acc_cnt++; end
            if (dump_req && req_cyc < 0) req_cyc = cyc;
            if (dump_valid && fv_cyc < 0) fv_cyc = cyc;
            if (dump_valid && dump_idx == 3'd3 && dump_data == 16'd13 && rf_readnum == 3'd3) stall_cnt++;

            m_done = 0;
            case (m_mode)
                0: if (beat) begin
                       shadow[0] = load_data; m_mode = 1; m_n = 1;
                   end else if (dump_req) begin
                       m_mode = 2; m_n = 0; m_fetch = 1;
                   end
                1: if (beat) begin
                       shadow[m_n] = load_data;
                       if (m_n == 7) begin m_mode = 0; m_n = 0; m_done = 1; end
                       else m_n++;
                   end
                default: if (m_fetch) begin
                       m_rdn = m_n; m_fetch = 0;
                   end else if (dump_ready) begin
                       if (m_n == 7) begin m_mode = 0; m_n = 0; m_done = 1; end
                       else begin m_n++; m_fetch = 1; end
                   end
            endcase
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int beats, guard;
        for (int i = 0; i < 8; i++) begin rf_mem[i] = '0; shadow[i] = '0; acc[i] = '0; end
        clr_stats();
        reset_n = 0; load_valid = 0; load_data = 0; dump_req = 0; dump_ready = 0;
        step(3);
        reset_n = 1;
        #1;
        chk("post_rst_ready", load_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Straight load of 10..17.
        clr_stats();
        load_valid = 1;
        for (int i = 0; i < 8; i++) begin load_data = 16'(10 + i); step(); end
        load_valid = 0;
        step(3);
        chk("load_wr_cnt", wr_cnt, 8);
        chk("load_busy_cnt", busy_cnt, 7);
        chk("load_done_cnt", done_cnt, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("rf_mem%0d", i), rf_mem[i], 10 + i);

        // Full dump, ready tied high.
        clr_stats();
        dump_ready = 1; dump_req = 1;
        step();
        dump_req = 0;
        step(20);
        chk("dump_first_latency", fv_cyc - req_cyc, 2);
        chk("dump_busy_cnt", busy_cnt, 16);
        chk("dump_done_cnt", done_cnt, 1);
        chk("dump_acc_cnt", acc_cnt, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("dump_word%0d", i), acc[i], 10 + i);

        // Dump with a five-cycle stall on R3.
        clr_stats();
        dump_req = 1;
        step();
        dump_req = 0;
        guard = 0;
        while (!(busy && !dump_valid && rf_readnum == 3'd3) && guard < 40) begin step(); guard++; end
        chk("stall_reach_idx3", guard < 40, 1);
        dump_ready = 0;
        step(6);
        dump_ready = 1;
        step(12);
        chk("stall_cnt", stall_cnt, 6);
        chk("stall_done_cnt", done_cnt, 1);

        // Load with random gaps; dump_req noise during the load.
        clr_stats();
        beats = 0; guard = 0;
        load_valid = 1; load_data = 16'($urandom);
        step(); beats++;
        while (beats < 8 && guard < 200) begin
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = 16'($urandom);
            dump_req   = $urandom_range(0, 1);
            step();
            if (load_valid) beats++;
            guard++;
        end
        load_valid = 0; dump_req = 0;
        step(2);
        chk("gap_wr_cnt", wr_cnt, 8);
        chk("gap_no_dump", valid_cnt, 0);
        dump_req = 1; step(); dump_req = 0;
        step(20);

        // Load and dump requested together: load wins.
        clr_stats();
        load_valid = 1; dump_req = 1; load_data = 16'hAA;
        step();
        load_valid = 0; dump_req = 0;
        step(3);
        chk("tie_r0", rf_mem[0], 16'hAA);
        chk("tie_busy", busy, 1);
        chk("tie_no_valid", valid_cnt, 0);
        load_valid = 1;
        for (int i = 1; i < 8; i++) begin load_data = 16'(16'hA0 + i); step(); end
        load_valid = 0;
        step(2);
        chk("tie_done_cnt", done_cnt, 1);

        // Reset in the middle of a load.
        clr_stats();
        load_valid = 1;
        for (int i = 0; i < 4; i++) begin load_data = 16'(16'h20 + i); step(); end
        load_data = 16'h24;
        reset_n = 0;
        #1;
        chk("abort_busy_now", busy, 0);
        chk("abort_write_now", rf_write, 0);
        step(2);
        reset_n = 1; load_data = 16'h55;
        step();
        load_valid = 0;
        step(3);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_r0", rf_mem[0], 16'h55);
        chk("abort_r4_kept", rf_mem[4], 16'hA4);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = 16'($urandom);
            dump_req   = ($urandom_range(0, 7) == 0);
            dump_ready = $urandom_range(0, 1);
            if (!reset_n) reset_n = 1;
            else if ($urandom_range(0, 149) == 0) reset_n = 0;
            step();
        end
        reset_n = 1; load_valid = 0; dump_req = 0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
